// File: rtl/alt_vipcts131_common_pkg.sv
// Shared helpers for the VIP common streaming blocks: sizing function,
// circular-index wrap helper and the show-ahead prefetch state encoding.
package alt_vipcts131_common_pkg;

    // Smallest legal FIFO depth; one word of storage cannot wrap meaningfully.
    localparam int FIFO_MIN_DEPTH = 2;

    // Status of the word behind the head in show-ahead mode.
    //   PF_IDLE  : fewer than two words held, nothing to prefetch
    //   PF_FETCH : second word was just written; held in the bypass register
    //              while the RAM read port catches up
    //   PF_VALID : RAM read register holds the second word
    typedef enum logic [1:0] {
        PF_IDLE  = 2'd0,
        PF_FETCH = 2'd1,
        PF_VALID = 2'd2
    } pf_state_t;

    // Smallest i with 2**i >= value.
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int i = 31; i >= 0; i--) begin
            if ((longint'(1) << i) >= longint'(value)) result = i;
        end
        return result;
    endfunction

    // Next index in a circular buffer of 'depth' entries (depth need not be 2**n).
    function automatic int wrap_inc(input int idx, input int depth);
        return (idx >= depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/alt_vipcts131_common_sc_fifo_ram.sv
// Simple dual-port RAM with a registered, enabled read port.
// Contents are not reset; only the read register is cleared.
module alt_vipcts131_common_sc_fifo_ram #(
    parameter int DATA_WIDTH = 20,
    parameter int DEPTH      = 1920,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: store one word per accepted write.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read port: registered output, refreshed only when enabled.
    always_ff @(posedge clock) begin
        if (!reset_n)   rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/alt_vipcts131_common_sc_fifo.sv
// Single-clock FIFO with normal or show-ahead read, any depth >= 2,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module alt_vipcts131_common_sc_fifo
    import alt_vipcts131_common_pkg::*;
#(
    parameter int DATA_WIDTH          = 20,
    parameter int FIFO_DEPTH          = 1920,
    parameter int SHOWAHEAD           = 0,
    parameter int ALMOST_FULL_THRESH  = FIFO_DEPTH - 4,
    parameter int ALMOST_EMPTY_THRESH = 4,
    parameter int USEDW_WIDTH         = clogb2(FIFO_DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   sclr,
    input  logic                   wrreq,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic                   rdreq,
    output logic [DATA_WIDTH-1:0]  q,
    output logic                   empty,
    output logic                   full,
    output logic [USEDW_WIDTH-1:0] usedw,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW   = (clogb2(FIFO_DEPTH) < 1) ? 1 : clogb2(FIFO_DEPTH);
    localparam int AF_T = (ALMOST_FULL_THRESH < 0) ? 0 :
                          (ALMOST_FULL_THRESH > FIFO_DEPTH) ? FIFO_DEPTH : ALMOST_FULL_THRESH;
    localparam int AE_T = (ALMOST_EMPTY_THRESH < 0) ? 0 :
                          (ALMOST_EMPTY_THRESH > FIFO_DEPTH) ? FIFO_DEPTH : ALMOST_EMPTY_THRESH;

    localparam logic [USEDW_WIDTH-1:0] AF_LVL    = USEDW_WIDTH'(AF_T);
    localparam logic [USEDW_WIDTH-1:0] AE_LVL    = USEDW_WIDTH'(AE_T);
    localparam logic [USEDW_WIDTH-1:0] DEPTH_LVL = USEDW_WIDTH'(FIFO_DEPTH);
    localparam logic [USEDW_WIDTH-1:0] ONE       = USEDW_WIDTH'(1);
    localparam logic [USEDW_WIDTH-1:0] TWO       = USEDW_WIDTH'(2);
    localparam logic [USEDW_WIDTH-1:0] THREE     = USEDW_WIDTH'(3);

    if (FIFO_DEPTH < FIFO_MIN_DEPTH) begin : g_depth_check
        $error("alt_vipcts131_common_sc_fifo: FIFO_DEPTH must be at least 2");
    end

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return AW'(wrap_inc(int'(p), FIFO_DEPTH));
    endfunction

    logic [AW-1:0]          wptr, rptr;
    logic [USEDW_WIDTH-1:0] usedw_nxt;
    logic                   run, wr_ok, rd_ok;
    logic                   ram_rd_en;
    logic [AW-1:0]          ram_rd_addr;
    logic [DATA_WIDTH-1:0]  ram_q;

    // Accept decisions and next occupancy; flush or reset forces occupancy to zero.
    always_comb begin
        run       = reset_n & ~sclr;
        wr_ok     = run & wrreq & ~full;
        rd_ok     = run & rdreq & ~empty;
        usedw_nxt = usedw;
        if (!run)                usedw_nxt = '0;
        else if (wr_ok && !rd_ok) usedw_nxt = usedw + ONE;
        else if (rd_ok && !wr_ok) usedw_nxt = usedw - ONE;
    end

    // Pointers, occupancy and all status flags, registered from the next occupancy.
    always_ff @(posedge clock) begin
        if (!reset_n || sclr) begin
            wptr         <= '0;
            rptr         <= '0;
            usedw        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= (AE_T > 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) wptr <= ptr_inc(wptr);
            if (rd_ok) rptr <= ptr_inc(rptr);
            usedw        <= usedw_nxt;
            empty        <= (usedw_nxt == '0);
            full         <= (usedw_nxt == DEPTH_LVL);
            almost_full  <= (usedw_nxt >= AF_LVL);
            almost_empty <= (usedw_nxt < AE_LVL);
            // A write at full is genuinely dropped, so it is always an error.
            if (wrreq && full) overflow <= 1'b1;
            // A read paired with a write into an empty FIFO just waits for that
            // word; only a lone read of an empty FIFO is an error.
            if (rdreq && empty && !wrreq) underflow <= 1'b1;
        end
    end

    alt_vipcts131_common_sc_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (wr_ok),
        .wr_addr (wptr),
        .wr_data (data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_q)
    );

    if (SHOWAHEAD == 0) begin : g_normal
        // Normal mode: the RAM read register is q; it loads only on an accepted read.
        assign ram_rd_en   = rd_ok;
        assign ram_rd_addr = rptr;
        assign q           = ram_q;
    end else begin : g_showahead
        pf_state_t              pf_state;
        logic [DATA_WIDTH-1:0]  head, byp, second_word;
        logic [AW-1:0]          rptr_p1, rptr_p2;
        logic [USEDW_WIDTH-1:0] prefetch_lvl;

        // The RAM always reads the word that will sit behind the head after
        // this edge, so a read can promote it to the head without a bubble.
        always_comb begin
            rptr_p1      = ptr_inc(rptr);
            rptr_p2      = ptr_inc(rptr_p1);
            ram_rd_addr  = rd_ok ? rptr_p2 : rptr_p1;
            prefetch_lvl = rd_ok ? THREE : TWO;
            second_word  = (pf_state == PF_FETCH) ? byp : ram_q;
        end
        assign ram_rd_en = 1'b1;

        // Head register and prefetch state machine.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                head     <= '0;
                byp      <= '0;
                pf_state <= PF_IDLE;
            end else if (sclr) begin
                pf_state <= PF_IDLE;
            end else begin
                if (wr_ok && (usedw == '0 || (usedw == ONE && rd_ok))) head <= data;
                else if (rd_ok)                                        head <= second_word;
                if (wr_ok) byp <= data;
                // The second word was already in RAM before this edge only if
                // enough words were held; otherwise it is the word being written.
                if (usedw_nxt < TWO)            pf_state <= PF_IDLE;
                else if (usedw >= prefetch_lvl) pf_state <= PF_VALID;
                else                            pf_state <= PF_FETCH;
            end
        end
        assign q = head;
    end

endmodule

// File: tb/tb_alt_vipcts131_common_sc_fifo.sv
// Bench for alt_vipcts131_common_sc_fifo: three instances (depth 8 normal,
// depth 5 normal, depth 8 show-ahead) share one stimulus stream and are each
// compared every cycle against a queue-based reference model.
module tb_alt_vipcts131_common_sc_fifo;

  localparam int W  = 20;
  localparam int NI = 3;

  typedef logic [W-1:0] word_t;

  // clock / reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic  reset_n, sclr, wrreq, rdreq;
  word_t data;

  word_t      q_o [NI];
  logic       empty_o [NI], full_o [NI], af_o [NI], ae_o [NI], ovf_o [NI], unf_o [NI];
  logic [3:0] usedw_a, usedw_c;
  logic [2:0] usedw_b;

  alt_vipcts131_common_sc_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(8), .SHOWAHEAD(0),
    .ALMOST_FULL_THRESH(4), .ALMOST_EMPTY_THRESH(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .sclr(sclr), .wrreq(wrreq), .data(data),
    .rdreq(rdreq), .q(q_o[0]), .empty(empty_o[0]), .full(full_o[0]), .usedw(usedw_a),
    .almost_full(af_o[0]), .almost_empty(ae_o[0]), .overflow(ovf_o[0]), .underflow(unf_o[0]));

  alt_vipcts131_common_sc_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(5), .SHOWAHEAD(0),
    .ALMOST_FULL_THRESH(1), .ALMOST_EMPTY_THRESH(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .sclr(sclr), .wrreq(wrreq), .data(data),
    .rdreq(rdreq), .q(q_o[1]), .empty(empty_o[1]), .full(full_o[1]), .usedw(usedw_b),
    .almost_full(af_o[1]), .almost_empty(ae_o[1]), .overflow(ovf_o[1]), .underflow(unf_o[1]));

  alt_vipcts131_common_sc_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(8), .SHOWAHEAD(1),
    .ALMOST_FULL_THRESH(4), .ALMOST_EMPTY_THRESH(4)) dut_c (
    .clock(clock), .reset_n(reset_n), .sclr(sclr), .wrreq(wrreq), .data(data),
    .rdreq(rdreq), .q(q_o[2]), .empty(empty_o[2]), .full(full_o[2]), .usedw(usedw_c),
    .almost_full(af_o[2]), .almost_empty(ae_o[2]), .overflow(ovf_o[2]), .underflow(unf_o[2]));

  // reference model: one queue of held words per instance
  int    dep    [NI] = '{8, 5, 8};
  int    af_thr [NI] = '{4, 1, 4};
  int    ae_thr [NI] = '{4, 4, 4};
  bit    sa     [NI] = '{1'b0, 1'b0, 1'b1};
  word_t exp_q  [NI][$];
  word_t mdl_q  [NI];
  bit    q_known[NI];
  bit    mdl_ovf[NI], mdl_unf[NI];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance the model by one clock edge using the inputs presented at that edge
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int    n;
      bit    is_full, is_empty, did_read;
      word_t v;
      did_read = 1'b0;
      if (!reset_n) begin
        exp_q[i].delete();
        mdl_q[i]   = '0;
        q_known[i] = 1'b1;
        mdl_ovf[i] = 1'b0;
        mdl_unf[i] = 1'b0;
      end else if (sclr) begin
        exp_q[i].delete();
        mdl_ovf[i] = 1'b0;
        mdl_unf[i] = 1'b0;
      end else begin
        n        = exp_q[i].size();
        is_full  = (n == dep[i]);
        is_empty = (n == 0);
        if (wrreq && is_full) mdl_ovf[i] = 1'b1;
        if (rdreq && is_empty && !wrreq) mdl_unf[i] = 1'b1;
        if (rdreq && !is_empty) begin
          v = exp_q[i].pop_front();
          did_read = 1'b1;
          if (!sa[i]) mdl_q[i] = v;
        end
        if (wrreq && !is_full) exp_q[i].push_back(data);
        if (sa[i]) begin
          if (exp_q[i].size() > 0) begin
            mdl_q[i]   = exp_q[i][0];
            q_known[i] = 1'b1;
          end else if (did_read) begin
            q_known[i] = 1'b0;
          end
        end
      end
    end
  endtask

  // compare every output of every instance against the model
  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      logic [31:0] uw;
      int n;
      n = exp_q[i].size();
      case (i)
        0:       uw = 32'(usedw_a);
        1:       uw = 32'(usedw_b);
        default: uw = 32'(usedw_c);
      endcase
      check($sformatf("usedw[%0d]", i), uw, 32'(n));
      check($sformatf("empty[%0d]", i), 32'(empty_o[i]), 32'(n == 0));
      check($sformatf("full[%0d]", i), 32'(full_o[i]), 32'(n == dep[i]));
      check($sformatf("almost_full[%0d]", i), 32'(af_o[i]), 32'(reset_n ? (n >= af_thr[i]) : 0));
      check($sformatf("almost_empty[%0d]", i), 32'(ae_o[i]), 32'(n < ae_thr[i]));
      check($sformatf("overflow[%0d]", i), 32'(ovf_o[i]), 32'(mdl_ovf[i]));
      check($sformatf("underflow[%0d]", i), 32'(unf_o[i]), 32'(mdl_unf[i]));
      if (q_known[i]) check($sformatf("q[%0d]", i), 32'(q_o[i]), 32'(mdl_q[i]));
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input bit w, input bit r, input word_t d);
    wrreq = w;
    rdreq = r;
    data  = d;
    tick();
  endtask

  task automatic flush();
    sclr = 1'b1;
    drive(1'b0, 1'b0, '0);
    sclr = 1'b0;
  endtask

  initial begin
    int pw, pr;
    reset_n = 1'b0;
    sclr    = 1'b0;
    wrreq   = 1'b0;
    rdreq   = 1'b0;
    data    = '0;
    for (int i = 0; i < NI; i++) begin
      mdl_q[i]   = '0;
      q_known[i] = 1'b0;
      mdl_ovf[i] = 1'b0;
      mdl_unf[i] = 1'b0;
    end

    // reset state
    tick();
    tick();
    check("rst_usedw_a", 32'(usedw_a), 32'd0);
    check("rst_empty_c", 32'(empty_o[2]), 32'd1);
    check("rst_ae_a", 32'(ae_o[0]), 32'd1);
    check("rst_q_a", 32'(q_o[0]), 32'd0);
    reset_n = 1'b1;

    // fill depth-8 instance in order
    for (int k = 1; k <= 8; k++) drive(1'b1, 1'b0, W'(k));
    check("fill_full_a", 32'(full_o[0]), 32'd1);
    check("fill_usedw_a", 32'(usedw_a), 32'd8);
    check("fill_af_a", 32'(af_o[0]), 32'd1);
    check("fill_ovf_b", 32'(ovf_o[1]), 32'd1);

    // write while full: flagged, contents untouched
    drive(1'b1, 1'b0, W'('hBAD));
    check("ovf_a", 32'(ovf_o[0]), 32'd1);
    check("ovf_usedw_a", 32'(usedw_a), 32'd8);

    // drain: q follows each accepted read by one edge, in write order
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, '0);
      check("rd_seq_a", 32'(q_o[0]), 32'(k));
    end
    check("drain_empty_a", 32'(empty_o[0]), 32'd1);

    // read while empty
    drive(1'b0, 1'b1, '0);
    check("unf_a", 32'(unf_o[0]), 32'd1);

    // flush clears sticky flags
    flush();
    check("sclr_ovf_a", 32'(ovf_o[0]), 32'd0);
    check("sclr_unf_a", 32'(unf_o[0]), 32'd0);
    check("sclr_usedw_a", 32'(usedw_a), 32'd0);
    check("sclr_empty_a", 32'(empty_o[0]), 32'd1);

    // empty with write+read: only the write lands, no underflow
    drive(1'b1, 1'b1, W'('h77));
    check("emp_both_usedw_a", 32'(usedw_a), 32'd1);
    check("emp_both_unf_a", 32'(unf_o[0]), 32'd0);

    // full with write+read: only the read lands
    for (int k = 1; k <= 7; k++) drive(1'b1, 1'b0, W'('h100 + k));
    drive(1'b1, 1'b1, W'('h99));
    check("full_both_usedw_a", 32'(usedw_a), 32'd7);
    check("full_both_q_a", 32'(q_o[0]), 32'h77);
    for (int k = 1; k <= 7; k++) drive(1'b0, 1'b1, '0);
    check("full_both_last_a", 32'(q_o[0]), 32'h107);

    // show-ahead: write into empty is visible right away
    flush();
    drive(1'b1, 1'b0, W'('hA));
    check("sa_empty_c", 32'(empty_o[2]), 32'd0);
    check("sa_q_c", 32'(q_o[2]), 32'hA);
    drive(1'b0, 1'b1, '0);
    check("sa_empty_after_rd_c", 32'(empty_o[2]), 32'd1);

    // non-power-of-2 wrap on the depth-5 instance
    flush();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, W'('h100 * (r + 1) + k));
      check("wrap_full_b", 32'(full_o[1]), 32'd1);
      for (int k = 0; k < 5; k++) begin
        drive(1'b0, 1'b1, '0);
        check("wrap_q_b", 32'(q_o[1]), 32'('h100 * (r + 1) + k));
      end
    end

    // steady streaming at usedw=3
    flush();
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, W'($urandom));
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, 1'b1, W'($urandom));
      check("stream_usedw_a", 32'(usedw_a), 32'd3);
    end

    // reset mid-operation with a concurrent write
    flush();
    for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, W'($urandom));
    reset_n = 1'b0;
    drive(1'b1, 1'b0, W'('h123));
    reset_n = 1'b1;
    check("midrst_usedw_a", 32'(usedw_a), 32'd0);
    check("midrst_empty_a", 32'(empty_o[0]), 32'd1);
    check("midrst_q_a", 32'(q_o[0]), 32'd0);

    // randomized traffic with shifting fill/drain bias
    pw = 50;
    pr = 50;
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) begin
        pw = $urandom_range(15, 90);
        pr = $urandom_range(15, 90);
      end
      sclr    = ($urandom_range(0, 149) == 0);
      reset_n = ($urandom_range(0, 399) != 0);
      drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, W'($urandom));
    end
    sclr    = 1'b0;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
